// File: rtl/event_timestamp.sv
// rtl/event_timestamp.sv - event time-stamping against the timer count with epoch extension
// Synchronised event edges capture {epoch, count} into a stamp FIFO for the readout logic.
module event_timestamp #(
  parameter int EPOCH_W    = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [27:0]           count,
  input  logic                  tclr,
  input  logic                  evt_in,
  input  logic                  evt_ena,
  input  logic                  rd_en,
  input  logic                  ovf_clr,
  output logic [EPOCH_W+27:0]   rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);
  localparam int SW    = EPOCH_W + 28;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [EPOCH_W-1:0] EPOCH_ONE = {{(EPOCH_W-1){1'b0}}, 1'b1};

  logic                sync1, sync2, sync3;
  logic [27:0]         count_d;
  logic                tclr_d;
  logic [EPOCH_W-1:0]  epoch;
  logic [EPOCH_W-1:0]  epoch_stamp;
  logic [SW-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2:0] wptr, rptr, wptr_nxt, rptr_nxt;
  logic                evt_rise, push_req, wrap, do_push, do_pop, lost;

  assign evt_rise = sync2 & ~sync3;
  assign push_req = evt_rise & evt_ena;

  // A wrap next to a clear is the clear itself, not a timer roll-over.
  assign wrap        = count_d[27] & ~count[27] & ~tclr & ~tclr_d;
  assign epoch_stamp = wrap ? epoch + EPOCH_ONE : epoch;

  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign do_pop   = rd_en & ~empty;
  assign do_push  = push_req & (~full | do_pop);
  assign lost     = push_req & full & ~do_pop;
  assign wptr_nxt = wptr + {{DEPTH_LOG2{1'b0}}, do_push};
  assign rptr_nxt = rptr + {{DEPTH_LOG2{1'b0}}, do_pop};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync3    <= 1'b0;
      count_d  <= '0;
      tclr_d   <= 1'b0;
      epoch    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      level    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      overflow <= 1'b0;
    end else begin
      sync1    <= evt_in;
      sync2    <= sync1;
      sync3    <= sync2;
      count_d  <= count;
      tclr_d   <= tclr;
      epoch    <= tclr ? '0 : epoch_stamp;
      wptr     <= wptr_nxt;
      rptr     <= rptr_nxt;
      empty    <= (wptr_nxt == rptr_nxt);
      full     <= (wptr_nxt[DEPTH_LOG2] != rptr_nxt[DEPTH_LOG2]) &&
                  (wptr_nxt[DEPTH_LOG2-1:0] == rptr_nxt[DEPTH_LOG2-1:0]);
      level    <= wptr_nxt - rptr_nxt;
      rd_valid <= do_pop;
      if (do_pop) begin
        rd_data <= mem[rptr[DEPTH_LOG2-1:0]];
      end
      if (lost) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[DEPTH_LOG2-1:0]] <= {epoch_stamp, count};
    end
  end

endmodule

// File: tb/tb_event_timestamp.sv
// tb/tb_event_timestamp.sv - self-checking bench for event_timestamp
// Directed test-plan scenarios followed by randomized traffic against a queue-based model.
module tb_event_timestamp;
  localparam int EPOCH_W    = 8;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int SW         = EPOCH_W + 28;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [27:0]         count = '0;
  logic                tclr = 1'b0;
  logic                evt_in = 1'b0;
  logic                evt_ena = 1'b0;
  logic                rd_en = 1'b0;
  logic                ovf_clr = 1'b0;
  logic [SW-1:0]       rd_data;
  logic                rd_valid;
  logic                empty;
  logic                full;
  logic [DEPTH_LOG2:0] level;
  logic                overflow;

  event_timestamp #(.EPOCH_W(EPOCH_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk(clk), .rst(rst), .count(count), .tclr(tclr), .evt_in(evt_in),
    .evt_ena(evt_ena), .rd_en(rd_en), .ovf_clr(ovf_clr), .rd_data(rd_data),
    .rd_valid(rd_valid), .empty(empty), .full(full), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: stamps held in a queue, epoch as a plain wrap counter.
  logic [SW-1:0] mq[$];
  logic [SW-1:0] m_rd_data    = '0;
  logic          m_rd_valid   = 1'b0;
  logic          m_ovf        = 1'b0;
  int unsigned   m_epoch      = 0;
  int unsigned   m_stamp_ep;
  logic [27:0]   m_count_prev = '0;
  logic          m_tclr_prev  = 1'b0;
  logic [2:0]    evt_hist     = '0;
  logic          m_wrap, m_push, m_lost;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_rd_data    = '0;
      m_rd_valid   = 1'b0;
      m_ovf        = 1'b0;
      m_epoch      = 0;
      m_count_prev = '0;
      m_tclr_prev  = 1'b0;
      evt_hist     = '0;
    end else begin
      m_wrap     = m_count_prev[27] && !count[27] && !tclr && !m_tclr_prev;
      m_stamp_ep = m_wrap ? (m_epoch + 1) % (1 << EPOCH_W) : m_epoch;
      // evt_in rising before edge k-2 (low before k-3) is captured at edge k
      m_push     = evt_hist[1] && !evt_hist[2] && evt_ena;
      m_lost     = 1'b0;
      m_rd_valid = rd_en && (mq.size() > 0);
      if (m_rd_valid) m_rd_data = mq.pop_front();
      if (m_push) begin
        if (mq.size() < DEPTH) mq.push_back({m_stamp_ep[EPOCH_W-1:0], count});
        else m_lost = 1'b1;
      end
      if (ovf_clr) m_ovf = 1'b0;
      if (m_lost) m_ovf = 1'b1;
      m_epoch      = tclr ? 0 : m_stamp_ep;
      m_count_prev = count;
      m_tclr_prev  = tclr;
      evt_hist     = {evt_hist[1:0], evt_in};
    end
  end

  task automatic check_outputs();
    check("rd_valid", rd_valid, m_rd_valid);
    check("rd_data", rd_data, m_rd_data);
    check("empty", empty, mq.size() == 0);
    check("full", full, mq.size() == DEPTH);
    check("level", level, mq.size());
    check("overflow", overflow, m_ovf);
  endtask

  // One clock: compare at the falling edge, then advance the timer stand-in.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    count = tclr ? 28'd0 : count + 28'd1;
  endtask

  logic [27:0]   pulse_cnt;
  logic [SW-1:0] last_data;
  int            hold = 2;
  int            rd_pct;

  // Pulse with minimum spacing; pulse_cnt is the count seen on the push edge.
  task automatic pulse_evt();
    pulse_cnt = count + 28'd2;
    evt_in = 1'b1;
    tick();
    tick();
    evt_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    // Reset and single event
    rst = 1'b0;
    repeat (3) tick();
    check("reset_empty", empty, 1'b1);
    check("reset_level", level, 0);
    rst = 1'b1;
    count = 28'd100;
    evt_ena = 1'b1;
    tick();
    pulse_evt();
    check("single_level", level, 1);
    pop1();
    check("single_valid", rd_valid, 1'b1);
    check("single_data", rd_data, {8'd0, pulse_cnt});
    check("single_empty", empty, 1'b1);
    tick();

    // Epoch wrap, then a timer clear
    count = 28'hFFFFFFE;
    pulse_evt();
    pop1();
    check("wrap_stamp", rd_data, {8'd1, 28'd0});
    tclr = 1'b1;
    tick();
    tclr = 1'b0;
    tick();
    pulse_evt();
    pop1();
    check("tclr_epoch", rd_data[SW-1:28], 0);
    check("tclr_count", rd_data[27:0], pulse_cnt);

    // Fill and overflow
    for (int i = 0; i < 17; i++) begin
      pulse_evt();
      if (i == 15) begin
        check("fill_full", full, 1'b1);
        check("fill_level", level, 16);
        check("fill_no_ovf", overflow, 1'b0);
      end
    end
    check("ovf_set", overflow, 1'b1);
    rd_en = 1'b1;
    repeat (16) tick();
    rd_en = 1'b0;
    check("drain_empty", empty, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 1'b0);

    // Push and pop on the same edge while full
    repeat (16) pulse_evt();
    pulse_cnt = count + 28'd2;
    evt_in = 1'b1;
    tick();
    tick();
    evt_in = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();
    check("pp_level", level, 16);
    check("pp_no_ovf", overflow, 1'b0);
    last_data = {8'd0, pulse_cnt};
    rd_en = 1'b1;
    repeat (16) tick();
    rd_en = 1'b0;
    check("pp_last", rd_data, last_data);

    // Enable gating and pop on empty
    evt_ena = 1'b0;
    pulse_evt();
    check("gated_level", level, 0);
    evt_ena = 1'b1;
    pop1();
    check("empty_pop", rd_valid, 1'b0);
    pulse_evt();
    pop1();
    check("after_gate", rd_data, {8'd0, pulse_cnt});

    // Mid-operation reset with a non-zero epoch and a pop in flight
    count = 28'hFFFFFF8;
    repeat (12) tick();
    repeat (5) pulse_evt();
    check("pre_rst_level", level, 5);
    rd_en = 1'b1;
    @(posedge clk);
    #2;
    check("pre_rst_valid", rd_valid, 1'b1);
    rst = 1'b0;
    #1;
    check("rst_valid", rd_valid, 1'b0);
    check("rst_data", rd_data, 0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_level", level, 0);
    check("rst_ovf", overflow, 1'b0);
    rd_en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    pulse_evt();
    pop1();
    check("post_rst_epoch", rd_data[SW-1:28], 0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rd_pct  = ((c / 1000) % 2 == 1) ? 40 : 5;
      rd_en   = ($urandom_range(0, 99) < rd_pct);
      ovf_clr = ($urandom_range(0, 99) < 3);
      evt_ena = ($urandom_range(0, 99) < 90);
      tclr    = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 299) == 0) count = 28'hFFFFFF0 | 28'($urandom_range(0, 15));
      if (hold > 0) begin
        hold--;
      end else if ($urandom_range(0, 1) == 1) begin
        evt_in = ~evt_in;
        hold = $urandom_range(1, 5);
      end
      tick();
    end
    rd_en = 1'b0;
    tclr = 1'b0;
    ovf_clr = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
